// File: rtl/reset_seq.sv
// Staged reset generator: asserts all reset outputs on power-up or software
// request, holds them, then releases them one stage at a time, lowest index first.
//
// state   | meaning
// --------+-----------------------------------------------
// ASSERT  | all rst_out high, counting the hold time
// RELEASE | staggered deassertion in progress
// IDLE    | all rst_out low, waiting for a request
module reset_seq #(
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic [N_OUT-1:0] rst_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_count
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0]    HOLD_TC  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    STAGE_TC = CW'(STAGE_DELAY - 1);
  localparam logic [N_OUT-1:0] LAST     = N_OUT'(1) << (N_OUT - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ASSERT;
      cnt       <= '0;
      rst_out   <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ASSERT: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == HOLD_TC) begin
            cnt <= '0;
            if (N_OUT == 1) begin
              state     <= IDLE;
              rst_out   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              seq_count <= seq_count + CNT_W'(1);
            end else begin
              state   <= RELEASE;
              rst_out <= rst_out << 1;
              busy    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RELEASE: begin
          // an abort request outranks the stage release, even on the final stage
          if (req) begin
            state   <= ASSERT;
            cnt     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
          end else if (cnt == STAGE_TC) begin
            cnt     <= '0;
            rst_out <= rst_out << 1;
            if (rst_out == LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              seq_count <= seq_count + CNT_W'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        IDLE: begin
          if (req) begin
            state   <= ASSERT;
            cnt     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
          end
        end

        default: begin
          state   <= ASSERT;
          cnt     <= '0;
          rst_out <= '1;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default instance for sequencing, aborts and
// mid-sequence reset; a 1-stage/1-cycle/2-bit-count instance for the corners.
module tb_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a = 1'b0, req_a = 1'b0;
  logic [2:0]  rst_out_a;
  logic        busy_a, done_a;
  logic [15:0] seq_count_a;

  logic        rst_n_b = 1'b0, req_b = 1'b0;
  logic [0:0]  rst_out_b;
  logic        busy_b, done_b;
  logic [1:0]  seq_count_b;

  reset_seq dut_a (
    .clk(clk), .rst_n(rst_n_a), .req(req_a),
    .rst_out(rst_out_a), .busy(busy_a), .done(done_a), .seq_count(seq_count_a)
  );

  reset_seq #(.N_OUT(1), .HOLD_CYCLES(1), .STAGE_DELAY(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b),
    .rst_out(rst_out_b), .busy(busy_b), .done(done_b), .seq_count(seq_count_b)
  );

  int errors = 0;
  int checks = 0;
  int done_pulses_a = 0;

  always @(posedge clk) if (rst_n_a && done_a) done_pulses_a <= done_pulses_a + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the last edge that restarted the hold (reset or req=1), with req now 0.
  task automatic full_seq(input int exp_count);
    repeat (15) tick();
    chk("hold_end_111", 32'(rst_out_a), 32'h7);
    tick();
    chk("stage0_110", 32'(rst_out_a), 32'h6);
    chk("stage0_busy", 32'(busy_a), 32'h1);
    repeat (3) tick();
    chk("stage1_pre_110", 32'(rst_out_a), 32'h6);
    tick();
    chk("stage1_100", 32'(rst_out_a), 32'h4);
    repeat (4) tick();
    chk("stage2_000", 32'(rst_out_a), 32'h0);
    chk("stage2_busy", 32'(busy_a), 32'h0);
    chk("stage2_done", 32'(done_a), 32'h1);
    chk("stage2_count", 32'(seq_count_a), 32'(exp_count));
    tick();
    chk("done_cleared", 32'(done_a), 32'h0);
    chk("idle_stays_000", 32'(rst_out_a), 32'h0);
  endtask

  initial begin
    int pulses_before;

    // power-up reset
    repeat (3) tick();
    chk("reset_rst_out", 32'(rst_out_a), 32'h7);
    chk("reset_busy", 32'(busy_a), 32'h1);
    chk("reset_done", 32'(done_a), 32'h0);
    chk("reset_count", 32'(seq_count_a), 32'h0);
    rst_n_a = 1'b1;
    full_seq(1);

    // one-cycle request from IDLE
    req_a = 1'b1;
    tick();
    chk("idle_req_111", 32'(rst_out_a), 32'h7);
    chk("idle_req_busy", 32'(busy_a), 32'h1);
    req_a = 1'b0;
    full_seq(2);

    // held request stretches ASSERT
    req_a = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("held_req_111", 32'(rst_out_a), 32'h7);
    end
    req_a = 1'b0;
    full_seq(3);

    // abort in RELEASE at 3'b100
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (16) tick();
    chk("abort_pre_110", 32'(rst_out_a), 32'h6);
    repeat (4) tick();
    chk("abort_pre_100", 32'(rst_out_a), 32'h4);
    pulses_before = done_pulses_a;
    req_a = 1'b1;
    tick();
    chk("abort_111", 32'(rst_out_a), 32'h7);
    chk("abort_done", 32'(done_a), 32'h0);
    chk("abort_count", 32'(seq_count_a), 32'h3);
    req_a = 1'b0;
    full_seq(4);
    chk("abort_one_done", 32'(done_pulses_a - pulses_before), 32'h1);

    // request on the cycle that would clear the last bit
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (20) tick();
    chk("race_pre_100", 32'(rst_out_a), 32'h4);
    repeat (3) tick();
    req_a = 1'b1;
    tick();
    chk("race_111", 32'(rst_out_a), 32'h7);
    chk("race_done", 32'(done_a), 32'h0);
    chk("race_count", 32'(seq_count_a), 32'h4);
    req_a = 1'b0;
    full_seq(5);

    // rst_n mid-sequence at 3'b110 with seq_count = 5
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (16) tick();
    chk("midrst_pre_110", 32'(rst_out_a), 32'h6);
    chk("midrst_pre_count", 32'(seq_count_a), 32'h5);
    rst_n_a = 1'b0;
    tick();
    chk("midrst_rst_out", 32'(rst_out_a), 32'h7);
    chk("midrst_busy", 32'(busy_a), 32'h1);
    chk("midrst_done", 32'(done_a), 32'h0);
    chk("midrst_count", 32'(seq_count_a), 32'h0);
    rst_n_a = 1'b1;

    // corner instance: single stage, 1-cycle hold, 2-bit wrapping count
    repeat (2) tick();
    chk("b_reset_rst_out", 32'(rst_out_b), 32'h1);
    chk("b_reset_busy", 32'(busy_b), 32'h1);
    rst_n_b = 1'b1;
    tick();
    chk("b_edge1_rst_out", 32'(rst_out_b), 32'h0);
    chk("b_edge1_done", 32'(done_b), 32'h1);
    chk("b_edge1_count", 32'(seq_count_b), 32'h1);
    tick();
    chk("b_done_cleared", 32'(done_b), 32'h0);
    for (int s = 2; s <= 4; s++) begin
      req_b = 1'b1;
      tick();
      chk("b_req_rst_out", 32'(rst_out_b), 32'h1);
      req_b = 1'b0;
      tick();
      chk("b_seq_done", 32'(done_b), 32'h1);
      chk("b_seq_count", 32'(seq_count_b), 32'(s % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
